// File: rtl/lane_pkg.sv
// Shared definitions for the lane detection back end (rho-max stage and peak selector).
package lane_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } lane_state_t;

    localparam int unsigned NUM_PHASE_DEF = 180;
    localparam int unsigned SPLIT_DEF     = 90;
    localparam int unsigned RHO_W_DEF     = 28;
    localparam int unsigned PH_W_DEF      = 8;

endpackage

// File: rtl/lane_peak_track.sv
// Running maximum of rho over one half of the phase range; the earliest phase wins a tie.
module lane_peak_track
    import lane_pkg::*;
#(
    parameter int unsigned RHO_W = RHO_W_DEF,
    parameter int unsigned PH_W  = PH_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [RHO_W-1:0] rho,
    input  logic [PH_W-1:0]  phase,
    output logic [RHO_W-1:0] max_rho,
    output logic [PH_W-1:0]  max_phase,
    output logic             seen
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_rho   <= '0;
            max_phase <= '0;
            seen      <= 1'b0;
        end else if (clear) begin
            // a sample arriving with the clear is the first of the new frame
            max_rho   <= en ? rho : '0;
            max_phase <= en ? phase : '0;
            seen      <= en;
        end else if (en && (!seen || rho > max_rho)) begin
            max_rho   <= rho;
            max_phase <= phase;
            seen      <= 1'b1;
        end
    end

endmodule

// File: rtl/lane_peak_sel.sv
// Per-frame left/right lane peak selector over Hough phases.
// Optional macro LANE_THRESH_EN: found flags require the winning rho to reach THRESH.
module lane_peak_sel
    import lane_pkg::*;
#(
    parameter int unsigned NUM_PHASE = NUM_PHASE_DEF,
    parameter int unsigned SPLIT     = SPLIT_DEF,
    parameter int unsigned RHO_W     = RHO_W_DEF,
    parameter int unsigned PH_W      = PH_W_DEF,
    parameter int unsigned THRESH    = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             in_vld,
    input  logic [RHO_W-1:0] rho_max,
    output logic             out_vld,
    output logic [RHO_W-1:0] left_rho,
    output logic [RHO_W-1:0] right_rho,
    output logic [PH_W-1:0]  left_phase,
    output logic [PH_W-1:0]  right_phase,
    output logic             left_found,
    output logic             right_found,
    output logic             overrun
);

    localparam logic [PH_W-1:0] SPLIT_PH = PH_W'(SPLIT);
    localparam logic [PH_W-1:0] LAST_PH  = PH_W'(NUM_PHASE - 1);

    if (SPLIT == 0 || SPLIT >= NUM_PHASE) begin : g_bad_split
        $error("lane_peak_sel: SPLIT must lie strictly inside the phase range");
    end
    if (PH_W < 32 && (1 << PH_W) < NUM_PHASE) begin : g_bad_ph_w
        $error("lane_peak_sel: PH_W too narrow for NUM_PHASE");
    end
    if (RHO_W < 32 && THRESH >= (1 << RHO_W)) begin : g_bad_thresh
        $error("lane_peak_sel: THRESH does not fit in RHO_W");
    end

    lane_state_t      state, state_nxt;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [PH_W-1:0]  samp_ph;
    logic             take, last_take, stray;
    logic             l_en, r_en;

    logic [RHO_W-1:0] l_max, r_max;
    logic [PH_W-1:0]  l_ph, r_ph;
    logic             l_seen, r_seen;
    logic             r_fin_new;
    logic [RHO_W-1:0] r_rho_fin;
    logic [PH_W-1:0]  r_ph_fin;

    always_comb begin
        take      = in_vld && (frame_start || state == COLLECT);
        samp_ph   = frame_start ? '0 : ph;
        l_en      = take && (samp_ph < SPLIT_PH);
        r_en      = take && !(samp_ph < SPLIT_PH);
        last_take = take && !frame_start && (ph == LAST_PH);
        stray     = in_vld && !frame_start && (state != COLLECT);
    end

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        if (frame_start) begin
            state_nxt = COLLECT;
            ph_nxt    = in_vld ? PH_W'(1) : '0;
        end else begin
            case (state)
                IDLE: ;
                COLLECT: begin
                    if (in_vld) begin
                        ph_nxt = ph + 1'b1;
                        if (ph == LAST_PH) state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ph    <= '0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
        end
    end

    lane_peak_track #(.RHO_W(RHO_W), .PH_W(PH_W)) u_left (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .en        (l_en),
        .rho       (rho_max),
        .phase     (samp_ph),
        .max_rho   (l_max),
        .max_phase (l_ph),
        .seen      (l_seen)
    );

    lane_peak_track #(.RHO_W(RHO_W), .PH_W(PH_W)) u_right (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_start),
        .en        (r_en),
        .rho       (rho_max),
        .phase     (samp_ph),
        .max_rho   (r_max),
        .max_phase (r_ph),
        .seen      (r_seen)
    );

    // The final phase always lands in the right half, so its sample is folded in
    // here to publish the result on the same edge the tracker absorbs it.
    always_comb begin
        r_fin_new = !r_seen || (rho_max > r_max);
        r_rho_fin = r_fin_new ? rho_max : r_max;
        r_ph_fin  = r_fin_new ? LAST_PH : r_ph;
    end

`ifdef LANE_THRESH_EN
    localparam logic [RHO_W-1:0] THR_W = RHO_W'(THRESH);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld     <= 1'b0;
            overrun     <= 1'b0;
            left_rho    <= '0;
            right_rho   <= '0;
            left_phase  <= '0;
            right_phase <= '0;
            left_found  <= 1'b0;
            right_found <= 1'b0;
        end else begin
            out_vld <= last_take;
            overrun <= stray;
            if (last_take) begin
                left_rho    <= l_max;
                left_phase  <= l_ph;
                right_rho   <= r_rho_fin;
                right_phase <= r_ph_fin;
`ifdef LANE_THRESH_EN
                left_found  <= l_seen && (l_max >= THR_W);
                right_found <= r_rho_fin >= THR_W;
`else
                left_found  <= l_seen;
                right_found <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lane_peak_sel.sv
// Self-checking bench for lane_peak_sel; honours LANE_THRESH_EN when defined.
module tb_lane_peak_sel;

    localparam int NP = 180;
    localparam int SP = 90;
    localparam int RW = 28;
    localparam int PW = 8;
    localparam int TH = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_vld = 1'b0;
    logic [RW-1:0] rho_max = '0;
    logic          out_vld, overrun, left_found, right_found;
    logic [RW-1:0] left_rho, right_rho;
    logic [PW-1:0] left_phase, right_phase;

    lane_peak_sel #(
        .NUM_PHASE (NP),
        .SPLIT     (SP),
        .RHO_W     (RW),
        .PH_W      (PW),
        .THRESH    (TH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_vld      (in_vld),
        .rho_max     (rho_max),
        .out_vld     (out_vld),
        .left_rho    (left_rho),
        .right_rho   (right_rho),
        .left_phase  (left_phase),
        .right_phase (right_phase),
        .left_found  (left_found),
        .right_found (right_found),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_vld  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: collect the raw samples, decide the winners once the frame is complete.
    logic [RW-1:0] samples[$];
    bit            collecting = 1'b0;
    logic          e_vld = 1'b0, e_ovr = 1'b0, e_lf = 1'b0, e_rf = 1'b0;
    logic [RW-1:0] e_lrho = '0, e_rrho = '0;
    logic [PW-1:0] e_lph = '0, e_rph = '0;

    function automatic void best(input int lo, input int hi, output logic [RW-1:0] m, output int idx);
        m = '0;
        for (int i = lo; i < hi; i++) if (samples[i] > m) m = samples[i];
        idx = -1;
        for (int i = lo; i < hi; i++) if (idx < 0 && samples[i] == m) idx = i;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld = 1'b0; e_ovr = 1'b0; e_lf = 1'b0; e_rf = 1'b0;
            e_lrho = '0; e_rrho = '0; e_lph = '0; e_rph = '0;
            collecting = 1'b0;
            samples.delete();
        end else begin
            e_vld = 1'b0;
            e_ovr = 1'b0;
            if (frame_start) begin
                samples.delete();
                collecting = 1'b1;
            end
            if (in_vld) begin
                if (collecting) begin
                    samples.push_back(rho_max);
                    if (samples.size() == NP) begin
                        logic [RW-1:0] lm, rm;
                        int li, ri;
                        best(0, SP, lm, li);
                        best(SP, NP, rm, ri);
                        e_lrho = lm; e_lph = PW'(li);
                        e_rrho = rm; e_rph = PW'(ri);
`ifdef LANE_THRESH_EN
                        e_lf = (lm >= RW'(TH));
                        e_rf = (rm >= RW'(TH));
`else
                        e_lf = 1'b1;
                        e_rf = 1'b1;
`endif
                        e_vld = 1'b1;
                        collecting = 1'b0;
                    end
                end else begin
                    e_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_vld", out_vld, e_vld);
            chk("overrun", overrun, e_ovr);
            chk("left_rho", left_rho, e_lrho);
            chk("left_phase", left_phase, e_lph);
            chk("right_rho", right_rho, e_rrho);
            chk("right_phase", right_phase, e_rph);
            chk("left_found", left_found, e_lf);
            chk("right_found", right_found, e_rf);
            if (out_vld === 1'b1) n_vld++;
        end
    end

    function automatic logic [RW-1:0] pat(input int kind, input int p);
        case (kind)
            0:       return RW'(p);
            1:       return (p == 10 || p == 20) ? RW'(500) : RW'(100);
            2:       return (p < SP) ? RW'(p % 50) : RW'((p - SP) % 51);
            default: return RW'(1000 - p);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic feed(input int kind, input int first, input int last);
        for (int p = first; p <= last; p++) begin
            in_vld  = 1'b1;
            rho_max = pat(kind, p);
            tick();
        end
        in_vld = 1'b0;
    endtask

    // Called right after the final sample's capture edge: the result must be up this cycle.
    task automatic expect_result(input string name, input int lr, input int lp, input int rr,
                                 input int rp, input bit lf, input bit rf);
        @(negedge clk);
        chk({name, "_vld"}, out_vld, 1);
        chk({name, "_lrho"}, left_rho, lr);
        chk({name, "_lph"}, left_phase, lp);
        chk({name, "_rrho"}, right_rho, rr);
        chk({name, "_rph"}, right_phase, rp);
        chk({name, "_lf"}, left_found, lf);
        chk({name, "_rf"}, right_found, rf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_vld", out_vld, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_lrho", left_rho, 0);
        chk("rst_rph", right_phase, 0);
        chk("rst_lf", left_found, 0);
        tick();

        start();
        feed(0, 0, NP - 1);
        expect_result("ramp", 89, 89, 179, 179, 1, 1);
        tick();

        start();
        feed(1, 0, NP - 1);
        expect_result("ties", 500, 10, 100, 90, 1, 1);
        tick();

        start();
        feed(2, 0, NP - 1);
`ifdef LANE_THRESH_EN
        expect_result("thresh", 49, 49, 50, 140, 0, 1);
`else
        expect_result("thresh", 49, 49, 50, 140, 1, 1);
`endif
        tick();

        v0 = n_vld;
        start();
        feed(3, 0, 59);
        start();
        feed(3, 0, NP - 1);
        expect_result("restart", 1000, 0, 910, 90, 1, 1);
        tick();
        tick();
        chk("restart_count", 64'(n_vld - v0), 1);

        in_vld  = 1'b1;
        rho_max = RW'(5);
        tick();
        in_vld = 1'b0;
        @(negedge clk);
        chk("idle_overrun", overrun, 1);
        chk("idle_hold_lrho", left_rho, 1000);
        tick();

        frame_start = 1'b1;
        in_vld      = 1'b1;
        rho_max     = RW'(900);
        tick();
        frame_start = 1'b0;
        feed(0, 1, NP - 1);
        expect_result("coinc", 900, 0, 179, 179, 1, 1);
        in_vld  = 1'b1;
        rho_max = RW'(7);
        tick();
        in_vld = 1'b0;
        @(negedge clk);
        chk("done_overrun", overrun, 1);
        tick();

        start();
        feed(0, 0, NP - 1);
        expect_result("ramp2", 89, 89, 179, 179, 1, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        @(negedge clk);
        chk("done_restart_hold", right_rho, 179);
        tick();
        feed(3, 0, 99);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("midrst_vld", out_vld, 0);
        chk("midrst_lrho", left_rho, 0);
        chk("midrst_rrho", right_rho, 0);
        chk("midrst_rph", right_phase, 0);
        chk("midrst_rf", right_found, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        start();
        feed(0, 0, NP - 1);
        expect_result("post_rst", 89, 89, 179, 179, 1, 1);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
